// File: rtl/main_mem_responder.sv
// ---------------------------------------------------------------------------
// main_mem_responder
//
// Backing-memory responder for a cache bank fill / eviction initiator.
// A read command is acknowledged with a one-cycle pulse, waits RD_LAT idle
// cycles, then streams 512 words of the selected bank out of a synchronous
// RAM as registered beats. A write (eviction) burst acknowledges and writes
// one word per cycle while wr_req is high, until 512 words are stored.
//
// Optional feature macro: MEM_RD_THROTTLE_EN
//   When defined, the read burst skips one issue slot after every three
//   issued words (2-bit phase counter), so 512 beats take 682 cycles.
//
// Parameters
//   DATA_W  width of one transfer word
//   BANK_W  width of the bank base address
//   RD_LAT  idle cycles between read ack and first RAM read issue (0 legal)
//
// Ports
//   clk          clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   rd_req       bank fill request (level, held until acked)
//   wr_req       eviction word valid (level, held for the whole burst)
//   bank_addr    bank base address, captured when a command is accepted
//   wr_data      eviction word, valid while wr_req is high
//   mem_wr_ack   read: command-accept pulse; write: per-word accept strobe
//   cache_wr_en  read beat valid strobe
//   rd_data      read beat data, zero when no beat
//   ram_addr     backing RAM word address {bank, word index}
//   ram_we       backing RAM write enable
//   ram_wdata    backing RAM write data
//   ram_rdata    backing RAM read data, valid one cycle after ram_addr
//   busy         high whenever the responder is not idle
// ---------------------------------------------------------------------------
module main_mem_responder #(
    parameter int DATA_W = 32,
    parameter int BANK_W = 7,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [BANK_W-1:0] bank_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_wr_ack,
    output logic              cache_wr_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [BANK_W+8:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACK,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [BANK_W-1:0] bank_q;
    // Bit 9 is the terminal flag: once set, the burst has moved all 512
    // words and no further issue or write can happen before IDLE.
    logic [9:0]        idx_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              beat_q;
    logic              rd_slot;
    logic              rd_issue;
    logic              wr_fire;
    logic              last_word;

    assign last_word = (idx_cnt[8:0] == 9'd511);

`ifdef MEM_RD_THROTTLE_EN
    logic [1:0] phase;

    // Phase 3 is a dead slot, giving a 3-on / 1-off issue pattern.
    assign rd_slot = (phase != 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 2'd0;
        end else if (state != RD_BURST && next_state == RD_BURST) begin
            phase <= 2'd0;
        end else if (state == RD_BURST) begin
            phase <= phase + 2'd1;
        end
    end
`else
    assign rd_slot = 1'b1;
`endif

    always_comb begin
        next_state = state;
        mem_wr_ack = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        rd_issue   = 1'b0;
        wr_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    next_state = WR_BURST;
                end else if (rd_req) begin
                    next_state = RD_ACK;
                end
            end
            RD_ACK: begin
                mem_wr_ack = 1'b1;
                next_state = (RD_LAT == 0) ? RD_BURST : RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    next_state = RD_BURST;
                end
            end
            RD_BURST: begin
                if (!idx_cnt[9] && rd_slot) begin
                    rd_issue = 1'b1;
                    ram_addr = {bank_q, idx_cnt[8:0]};
                    if (last_word) begin
                        next_state = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (wr_req && !idx_cnt[9]) begin
                    wr_fire    = 1'b1;
                    mem_wr_ack = 1'b1;
                    ram_we     = 1'b1;
                    ram_addr   = {bank_q, idx_cnt[8:0]};
                    ram_wdata  = wr_data;
                    if (last_word) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                // Wait for the initiator to release both requests so a
                // lingering wr_req cannot start a second burst.
                if (!rd_req && !wr_req) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bank_q  <= '0;
            idx_cnt <= '0;
            lat_cnt <= '0;
            beat_q  <= 1'b0;
        end else begin
            state  <= next_state;
            beat_q <= rd_issue;
            if (state == IDLE) begin
                idx_cnt <= '0;
                lat_cnt <= '0;
                if (next_state != IDLE) begin
                    bank_q <= bank_addr;
                end
            end else if (rd_issue || wr_fire) begin
                idx_cnt <= idx_cnt + 10'd1;
            end
            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
        end
    end

    // The RAM output register holds the beat data; the beat strobe is
    // registered alongside it, and data is forced to zero outside beats so
    // a read in flight during reset never shows up on rd_data.
    assign cache_wr_en = beat_q;
    assign rd_data     = beat_q ? ram_rdata : '0;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_main_mem_responder
//
// Directed bench for main_mem_responder with a synchronous RAM model.
// Read beats and write words are pushed to scoreboards when the command is
// driven and popped when the responder produces them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_main_mem_responder;

    localparam int DATA_W = 32;
    localparam int BANK_W = 7;
`ifdef MEM_RD_THROTTLE_EN
    localparam int RD_LAT = 0;
`else
    localparam int RD_LAT = 4;
`endif
    localparam int WORDS = 512;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic              wr_req;
    logic [BANK_W-1:0] bank_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_wr_ack;
    logic              cache_wr_en;
    logic [DATA_W-1:0] rd_data;
    logic [BANK_W+8:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    typedef struct {
        int          idx;
        int          cyc;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    rd_exp_t     rdQ[$];
    wr_exp_t     wrQ[$];
    logic [31:0] ramArr [0:65535];
    bit          written [0:65535];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    main_mem_responder #(
        .DATA_W(DATA_W),
        .BANK_W(BANK_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .bank_addr  (bank_addr),
        .wr_data    (wr_data),
        .mem_wr_ack (mem_wr_ack),
        .cache_wr_en(cache_wr_en),
        .rd_data    (rd_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    // Unwritten locations return a fixed address-derived pattern.
    function automatic logic [31:0] memInit(input logic [15:0] a);
        return 32'hC0DE_0000 ^ {16'h0000, a};
    endfunction

    // Beat n arrives this many cycles after the read ack cycle.
    function automatic int beatCycle(input int n);
`ifdef MEM_RD_THROTTLE_EN
        return RD_LAT + 2 + n + (n / 3);
`else
        return RD_LAT + 2 + n;
`endif
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            ramArr[ram_addr]  <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= written[ram_addr] ? ramArr[ram_addr] : memInit(ram_addr);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [BANK_W-1:0] b, input logic [31:0] d);
        rd_req    = r;
        wr_req    = w;
        bank_addr = b;
        wr_data   = d;
    endtask

    task automatic runRead(input logic [BANK_W-1:0] bank, input int abortAt);
        int      cyc;
        int      got;
        int      badAck;
        rd_exp_t e;
        logic [15:0] a;
        cyc    = 0;
        got    = 0;
        badAck = 0;
        applyStimulus(1'b1, 1'b0, bank, 32'd0);
        for (int i = 0; i < WORDS; i++) begin
            a      = {bank, 9'(i)};
            e.idx  = i;
            e.cyc  = beatCycle(i);
            e.data = memInit(a);
            rdQ.push_back(e);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, bank, 32'd0);
        @(negedge clk);
        checkOutput("rd_ack_pulse", 64'(mem_wr_ack), 64'd1);
        checkOutput("rd_ack_busy", 64'(busy), 64'd1);
        while (rdQ.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (mem_wr_ack) badAck++;
            if (cache_wr_en) begin
                e = rdQ.pop_front();
                got++;
                checkOutput("rd_beat_data", 64'(rd_data), 64'(e.data));
                checkOutput("rd_beat_cycle", 64'(cyc), 64'(e.cyc));
                if (e.idx == abortAt) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    @(negedge clk);
                    checkOutput("rst_cache_wr_en", 64'(cache_wr_en), 64'd0);
                    checkOutput("rst_busy", 64'(busy), 64'd0);
                    checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
                    checkOutput("rst_ram_addr", 64'(ram_addr), 64'd0);
                    checkOutput("rst_ack", 64'(mem_wr_ack), 64'd0);
                    @(negedge clk);
                    checkOutput("rst_no_late_beat", 64'(cache_wr_en), 64'd0);
                    rdQ.delete();
                end
            end
        end
        checkOutput("rd_pending_beats", 64'(rdQ.size()), 64'd0);
        checkOutput("rd_beat_count", 64'(got), 64'((abortAt < 0) ? WORDS : abortAt + 1));
        checkOutput("rd_no_extra_ack", 64'(badAck), 64'd0);
        @(negedge clk);
        checkOutput("rd_end_no_beat", 64'(cache_wr_en), 64'd0);
        checkOutput("rd_end_idle", 64'(busy), 64'd0);
    endtask

    task automatic runWrite(input logic [BANK_W-1:0] bank, input int gapAt,
                            input logic withRd);
        int      cyc;
        int      sent;
        int      gapCycles;
        int      unexpected;
        int      beats;
        logic    pending;
        wr_exp_t e;
        cyc        = 0;
        sent       = 0;
        gapCycles  = 0;
        unexpected = 0;
        beats      = 0;
        e.addr     = {bank, 9'd0};
        e.data     = 32'd0;
        wrQ.push_back(e);
        pending    = 1'b1;
        applyStimulus(withRd, 1'b1, bank, 32'd0);
        @(posedge clk); #1;
        while (sent < WORDS && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cache_wr_en) beats++;
            if (!wr_req) begin
                checkOutput("wr_gap_quiet", 64'({mem_wr_ack, ram_we}), 64'd0);
            end
            if (mem_wr_ack) begin
                if (wrQ.size() == 0) begin
                    unexpected++;
                end else begin
                    e = wrQ.pop_front();
                    checkOutput("wr_addr", 64'(ram_addr), 64'(e.addr));
                    checkOutput("wr_data", 64'(ram_wdata), 64'(e.data));
                    checkOutput("wr_we", 64'(ram_we), 64'd1);
                end
                pending = 1'b0;
                sent++;
            end else if (ram_we) begin
                unexpected++;
            end
            @(posedge clk); #1;
            if (sent < WORDS) begin
                if (sent == gapAt && gapCycles < 3) begin
                    applyStimulus(withRd, 1'b0, bank, 32'd0);
                    gapCycles++;
                end else if (!pending) begin
                    e.addr = {bank, 9'(sent)};
                    e.data = 32'(sent);
                    wrQ.push_back(e);
                    pending = 1'b1;
                    applyStimulus(withRd, 1'b1, bank, 32'(sent));
                end
            end
        end
        checkOutput("wr_ack_count", 64'(sent), 64'(WORDS));
        checkOutput("wr_unexpected", 64'(unexpected), 64'd0);
        checkOutput("wr_gap_cycles", 64'(gapCycles), 64'((gapAt < 0) ? 0 : 3));
        checkOutput("wr_no_read_beats", 64'(beats), 64'd0);
        // Initiator keeps wr_req up for two cycles past the last ack.
        repeat (2) begin
            @(negedge clk);
            checkOutput("wr_hold_quiet", 64'({mem_wr_ack, ram_we, cache_wr_en}), 64'd0);
            checkOutput("wr_hold_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b0, bank, 32'd0);
        @(negedge clk);
        checkOutput("wr_done_busy", 64'(busy), 64'd1);
        @(negedge clk);
        checkOutput("wr_back_idle", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("wr_stay_idle", 64'({busy, mem_wr_ack, cache_wr_en}), 64'd0);
    endtask

    task automatic checkRam(input logic [BANK_W-1:0] bank);
        int          bad;
        logic [15:0] a;
        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            a = {bank, 9'(i)};
            if (!written[a] || ramArr[a] !== 32'(i)) bad++;
        end
        checkOutput("ram_contents", 64'(bad), 64'd0);
        a = {bank, 9'd100};
        checkOutput("ram_word100", 64'(ramArr[a]), 64'd100);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, '0, 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_ack", 64'(mem_wr_ack), 64'd0);
        checkOutput("reset_cache_wr_en", 64'(cache_wr_en), 64'd0);
        checkOutput("reset_ram_we", 64'(ram_we), 64'd0);
        checkOutput("reset_ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("reset_ram_wdata", 64'(ram_wdata), 64'd0);
        checkOutput("reset_rd_data", 64'(rd_data), 64'd0);

        $display("[TB] read burst, bank 0x05");
        runRead(7'h05, -1);

        $display("[TB] write burst, bank 0x7F, extra wr_req hold");
        runWrite(7'h7F, -1, 1'b0);
        checkRam(7'h7F);

        $display("[TB] write burst, bank 0x22, gap at word 100");
        runWrite(7'h22, 100, 1'b0);
        checkRam(7'h22);

        $display("[TB] read burst, bank 0x11, reset at beat 200");
        runRead(7'h11, 200);

        $display("[TB] read burst, bank 0x11, restart after reset");
        runRead(7'h11, -1);

        $display("[TB] rd_req and wr_req together, bank 0x33");
        runWrite(7'h33, -1, 1'b1);
        checkRam(7'h33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one transfer word.
REQ-002 SHALL have parameter BANK_W, default 7, width of bank base address.
REQ-003 SHALL have parameter RD_LAT, default 4, idle cycles between read-command ack and first RAM read issue (0 legal).
REQ-004 SHALL have ports: clk  in  1  clock; one clock only, all logic on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rd_req  in  1  initiator requests bank fill; level, held until acked.
REQ-007 wr_req  in  1  initiator evicting a dirty bank; level, held for whole burst.
REQ-008 bank_addr  in  BANK_W  bank base address, sampled on command accept.
REQ-009 wr_data  in  DATA_W  eviction word, valid while wr_req is high.
REQ-010 mem_wr_ack  out  1  read: one-cycle command-accept pulse; write: per-word accept strobe.
REQ-011 cache_wr_en  out  1  read beat valid strobe.
REQ-012 rd_data  out  DATA_W  read beat data, valid when cache_wr_en is high.
REQ-013 ram_addr  out  BANK_W+9  backing RAM word address {bank, word index}.
REQ-014 ram_we  out  1  backing RAM write enable.
REQ-015 ram_wdata  out  DATA_W  backing RAM write data.
REQ-016 ram_rdata  in  DATA_W  backing RAM read data, valid exactly 1 cycle after address.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, RD_ACK, RD_WAIT, RD_BURST, WR_BURST, DONE.
REQ-019 IDLE: wr_req high -> WR_BURST; else rd_req high -> RD_ACK; bank_addr latched on that transition; wr_req wins if both high.
REQ-020 RD_ACK: mem_wr_ack high exactly this one cycle; next state RD_WAIT.
REQ-021 RD_WAIT: stays RD_LAT cycles (0 -> skip directly to RD_BURST next cycle).
REQ-022 RD_BURST: each issue cycle drives ram_addr={bank, idx}, idx increments; after idx 511 issued -> DONE.
REQ-023 cache_wr_en and rd_data SHALL be registered: beat for idx N appears exactly 1 cycle after idx N issued, rd_data = ram_rdata.
REQ-024 A read burst SHALL deliver exactly 512 beats, indices 0..511 in order; last beat may coincide with first DONE cycle.
REQ-025 WR_BURST: each cycle wr_req is high: mem_wr_ack=1, ram_we=1, ram_addr={bank, idx}, ram_wdata=wr_data, idx increments; cycles with wr_req low produce no ack and no write.
REQ-026 After the 512th write ack -> DONE; no further acks or writes that burst.
REQ-027 DONE: no ack, no write, no beat; stays until rd_req and wr_req both low, then IDLE (covers initiator holding wr_req 2 cycles past last ack).
REQ-028 Word index SHALL be 9 bits plus a terminal flag; no wrap into a second burst.
REQ-029 mem_wr_ack SHALL never be high in RD_WAIT, RD_BURST or DONE.

Reset
REQ-030 rst high at any cycle, including mid-burst, SHALL on the next edge force IDLE, idx=0, latency counter=0, and mem_wr_ack, cache_wr_en, ram_we, busy = 0; rd_data, ram_addr, ram_wdata = 0.
REQ-031 A pending in-flight read beat SHALL be discarded by reset, never emitted.

Configuration
REQ-032 Macro MEM_RD_THROTTLE_EN: when defined, a 2-bit phase counter, cleared on RD_BURST entry, increments every RD_BURST cycle; no read issued in cycles with phase==3, so 512 beats take 682 issue cycles with a one-cycle gap after every 3 beats.
REQ-033 Without MEM_RD_THROTTLE_EN: issue every RD_BURST cycle, 512 consecutive beats; no phase counter exists.

Verification
REQ-034 Read, RD_LAT=4, bank_addr=7'h05: rd_req high -> mem_wr_ack pulse 1 cycle after, first cache_wr_en 6 cycles after ack, 512 contiguous beats, rd_data = RAM[0xA00..0xBFF].
REQ-035 Write, bank_addr=7'h7F, wr_data=index: 512 acks, RAM[0xFE00+i]=i, wr_req held 2 extra cycles -> no 513th ack, DONE until wr_req low.
REQ-036 Write with wr_req dropped 3 cycles at word 100 -> no acks/writes during gap, burst resumes at idx 100, total 512 writes.
REQ-037 rst asserted at read beat 200 -> next cycle cache_wr_en=0, busy=0; new rd_req restarts at idx 0.
REQ-038 rd_req and wr_req both high in IDLE -> write burst taken, no read ack.
REQ-039 MEM_RD_THROTTLE_EN defined, RD_LAT=0 -> beat pattern 3 on/1 off, 512 beats over 682 cycles.
